// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
//   Shared definitions for the interrupt collector: the FSM state encoding
//   and the default source count / id width used by the interface, the
//   priority encoder and the top level.
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  // Two-state request FSM. IRQ_IDLE arbitrates, IRQ_ACTIVE holds a request
  // until the consumer acknowledges the in-service id.
  typedef enum logic {
    IRQ_IDLE   = 1'b0,
    IRQ_ACTIVE = 1'b1
  } irq_state_t;

  localparam int NUM_SRC_DEF = 4;
  localparam int ID_W_DEF    = 2;

endpackage : irq_ctrl_pkg

// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if
//   Bundle of every functional signal of irq_ctrl except clk/rst_n.
//
//   Handshake: irq/irq_id form a level request. Once irq is 1 it stays 1 and
//   irq_id stays stable until the consumer presents ack_valid=1 for one cycle
//   with ack_id equal to irq_id; that edge retires the request. Any other
//   ack_valid (no request outstanding, or wrong id) is ignored and answered
//   with a one-cycle ack_err pulse on the following cycle.
//
//   Signals
//     irq_pulse  timers -> ctrl  one-cycle interrupt pulse per source
//     mask_we    sw     -> ctrl  mask write strobe
//     mask_wdata sw     -> ctrl  new mask, 1 = source enabled
//     ack_valid  cons   -> ctrl  acknowledge strobe
//     ack_id     cons   -> ctrl  id being acknowledged
//     irq        ctrl   -> cons  request, registered
//     irq_id     ctrl   -> cons  in-service id, registered
//     pending    ctrl   -> sw    pending bits, registered
//     overrun    ctrl   -> sw    sticky overrun bits, registered
//     ack_err    ctrl   -> cons  one-cycle pulse: ack ignored
//     dbg_state  ctrl   -> dbg   current FSM state
//     dbg_mask   ctrl   -> dbg   current mask register
//
//   Modports: slave = irq_ctrl side, master = environment side.
// -----------------------------------------------------------------------------
interface irq_ctrl_if
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) ();

  logic [NUM_SRC-1:0] irq_pulse;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               ack_valid;
  logic [ID_W-1:0]    ack_id;

  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overrun;
  logic               ack_err;

  irq_state_t         dbg_state;
  logic [NUM_SRC-1:0] dbg_mask;

  modport slave (
    input  irq_pulse, mask_we, mask_wdata, ack_valid, ack_id,
    output irq, irq_id, pending, overrun, ack_err, dbg_state, dbg_mask
  );

  modport master (
    output irq_pulse, mask_we, mask_wdata, ack_valid, ack_id,
    input  irq, irq_id, pending, overrun, ack_err, dbg_state, dbg_mask
  );

endinterface : irq_ctrl_if

// File: rtl/irq_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_ctrl_prio_enc
//   Combinational lowest-index-first priority encoder. Index 0 has the
//   highest priority.
//
//   Ports
//     i_req    in   NUM_SRC  request vector (pending & mask)
//     o_found  out  1        at least one request bit set
//     o_id     out  ID_W     index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module irq_ctrl_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_found,
  output logic [ID_W-1:0]    o_id
);

  // Scan from the top down so the last hit, i.e. the lowest index, wins.
  always_comb begin
    o_found = 1'b0;
    o_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end

endmodule : irq_ctrl_prio_enc

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//   Interrupt collector behind the minipit timers. Latches one-cycle
//   interrupt pulses into pending bits, flags overruns, applies a per-source
//   mask and presents a single prioritised request that is held until an
//   id-matched acknowledge.
//
//   Ports
//     clk    in  1   clock, all state on posedge
//     rst_n  in  1   synchronous active-low reset
//     bus    irq_ctrl_if.slave  (see irq_ctrl_if for the signal list and
//                                the request/acknowledge handshake)
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input logic       clk,
  input logic       rst_n,
  irq_ctrl_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  irq_state_t         r_state;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_overrun;
  logic [NUM_SRC-1:0] r_mask;
  logic               r_irq;
  logic [ID_W-1:0]    r_irq_id;
  logic               r_ack_err;

  // ---------------------------------------------------------------------------
  // Arbitration and acknowledge decode
  // ---------------------------------------------------------------------------
  logic               w_found;
  logic [ID_W-1:0]    w_enc_id;
  logic               w_ack_ok;
  logic [NUM_SRC-1:0] w_clr;

  // Arbitration looks only at the registered pending/mask, so a pulse or a
  // mask write on the same edge is seen one cycle later.
  irq_ctrl_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .i_req   (r_pending & r_mask),
    .o_found (w_found),
    .o_id    (w_enc_id)
  );

  // irq_id only ever holds an index below NUM_SRC while ACTIVE, so an ack_id
  // at or above NUM_SRC can never match and falls through to ack_err.
  assign w_ack_ok = bus.ack_valid && (r_state == IRQ_ACTIVE) &&
                    (bus.ack_id == r_irq_id);

  // One-hot clear of the in-service source on a valid ack.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_ack_ok && (r_irq_id == ID_W'(i))) begin
        w_clr[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers and FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IRQ_IDLE;
      r_pending <= '0;
      r_overrun <= '0;
      r_mask    <= '1;
      r_irq     <= 1'b0;
      r_irq_id  <= '0;
      r_ack_err <= 1'b0;
    end else begin
      // A new pulse beats the clear, so a source re-fired on its own ack edge
      // stays pending. That case is a fresh event, not an overrun, hence the
      // ~w_clr on the overrun set term.
      r_pending <= (r_pending & ~w_clr) | bus.irq_pulse;
      r_overrun <= (r_overrun & ~w_clr) | (bus.irq_pulse & r_pending & ~w_clr);

      // Masking only gates arbitration; a request already in service is kept.
      if (bus.mask_we) begin
        r_mask <= bus.mask_wdata;
      end

      r_ack_err <= bus.ack_valid && !w_ack_ok;

      case (r_state)
        IRQ_IDLE: begin
          if (w_found) begin
            r_state  <= IRQ_ACTIVE;
            r_irq    <= 1'b1;
            r_irq_id <= w_enc_id;
          end
        end
        IRQ_ACTIVE: begin
          // irq_id is left untouched on exit; the one IDLE cycle that follows
          // produces the single low cycle between back-to-back requests.
          if (w_ack_ok) begin
            r_state <= IRQ_IDLE;
            r_irq   <= 1'b0;
          end
        end
        default: begin
          r_state <= IRQ_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.irq       = r_irq;
  assign bus.irq_id    = r_irq_id;
  assign bus.pending   = r_pending;
  assign bus.overrun   = r_overrun;
  assign bus.ack_err   = r_ack_err;
  assign bus.dbg_state = r_state;
  assign bus.dbg_mask  = r_mask;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
//   Bench for irq_ctrl: a table of hand-computed vectors for the directed
//   scenarios, a hand-written reset-during-service sequence, and a random
//   phase scored against a behavioural model of the collector.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NS = 4;
  localparam int IW = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_SRC(NS), .ID_W(IW)) bus ();

  irq_ctrl #(.NUM_SRC(NS), .ID_W(IW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: arrays of per-source flags plus "is a request being
  // served, and which one".
  // ---------------------------------------------------------------------------
  bit m_pend [NS];
  bit m_ovr  [NS];
  bit m_mask [NS];
  bit m_busy;
  int m_id;
  bit m_err;

  function automatic logic [NS-1:0] to_vec(input bit a [NS]);
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_step(input bit rst, input logic [NS-1:0] pulse,
                            input bit mwe, input logic [NS-1:0] mwd,
                            input bit ackv, input logic [IW-1:0] ackid);
    bit good;
    int served;
    int winner;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_pend[i] = 0; m_ovr[i] = 0; m_mask[i] = 1;
      end
      m_busy = 0; m_id = 0; m_err = 0;
      return;
    end
    served = m_id;
    good   = ackv && m_busy && (int'(ackid) == m_id);
    m_err  = ackv && !good;
    // Pick the highest-priority enabled pending source seen before this edge.
    winner = -1;
    for (int i = NS - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) winner = i;
    if (!m_busy) begin
      if (winner >= 0) begin m_busy = 1; m_id = winner; end
    end else if (good) begin
      m_busy = 0;
    end
    for (int i = 0; i < NS; i++) begin
      bit retire;
      retire = good && (i == served);
      if (retire) m_ovr[i] = 0;
      else if (pulse[i] && m_pend[i]) m_ovr[i] = 1;
      if (pulse[i]) m_pend[i] = 1;
      else if (retire) m_pend[i] = 0;
      if (mwe) m_mask[i] = mwd[i];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, clock one edge, advance the model, sample at +1.
  // ---------------------------------------------------------------------------
  task automatic drive(input bit rst, input logic [NS-1:0] pulse,
                       input bit mwe, input logic [NS-1:0] mwd,
                       input bit ackv, input logic [IW-1:0] ackid);
    rst_n          = !rst;
    bus.irq_pulse  = pulse;
    bus.mask_we    = mwe;
    bus.mask_wdata = mwd;
    bus.ack_valid  = ackv;
    bus.ack_id     = ackid;
    @(posedge clk);
    model_step(rst, pulse, mwe, mwd, ackv, ackid);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NS-1:0] pulse;
    logic          mwe;
    logic [NS-1:0] mwd;
    logic          ackv;
    logic [IW-1:0] ackid;
    logic          e_irq;
    logic [IW-1:0] e_id;
    logic [NS-1:0] e_pend;
    logic [NS-1:0] e_ovr;
    logic          e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [NS-1:0] pulse, input logic mwe,
                     input logic [NS-1:0] mwd, input logic ackv,
                     input logic [IW-1:0] ackid, input logic e_irq,
                     input logic [IW-1:0] e_id, input logic [NS-1:0] e_pend,
                     input logic [NS-1:0] e_ovr, input logic e_err);
    vec_t v;
    v.pulse = pulse; v.mwe = mwe; v.mwd = mwd; v.ackv = ackv; v.ackid = ackid;
    v.e_irq = e_irq; v.e_id = e_id; v.e_pend = e_pend; v.e_ovr = e_ovr;
    v.e_err = e_err;
    vq.push_back(v);
  endtask

  // Scoreboard queue for the random phase: {irq, irq_id, pending, overrun, ack_err}
  logic [11:0] exp_q[$];

  initial begin
    logic [11:0] e;
    rst_n          = 1'b0;
    bus.irq_pulse  = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.ack_valid  = 1'b0;
    bus.ack_id     = '0;

    //    pulse   mwe mwd     ackv id     irq id    pend    ovr     err
    // single source, ack
    add(4'b0100, 0, 4'b0000, 0, 2'd0,   0, 2'd0, 4'b0100, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd2, 4'b0100, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd2,   0, 2'd2, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   0, 2'd2, 4'b0000, 4'b0000, 0);
    // two sources, priority and one-cycle gap
    add(4'b1010, 0, 4'b0000, 0, 2'd0,   0, 2'd2, 4'b1010, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd1, 4'b1010, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd1,   0, 2'd1, 4'b1000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd3, 4'b1000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd3,   0, 2'd3, 4'b0000, 4'b0000, 0);
    // overrun and its clear on ack
    add(4'b0001, 0, 4'b0000, 0, 2'd0,   0, 2'd3, 4'b0001, 4'b0000, 0);
    add(4'b0001, 0, 4'b0000, 0, 2'd0,   1, 2'd0, 4'b0001, 4'b0001, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd0,   0, 2'd0, 4'b0000, 4'b0000, 0);
    // masked source stays pending until unmasked
    add(4'b0000, 1, 4'b1110, 0, 2'd0,   0, 2'd0, 4'b0000, 4'b0000, 0);
    add(4'b0001, 0, 4'b0000, 0, 2'd0,   0, 2'd0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   0, 2'd0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 1, 4'b1111, 0, 2'd0,   0, 2'd0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd0,   0, 2'd0, 4'b0000, 4'b0000, 0);
    // wrong-id ack while active, ack while idle
    add(4'b0100, 0, 4'b0000, 0, 2'd0,   0, 2'd0, 4'b0100, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd2, 4'b0100, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd1,   1, 2'd2, 4'b0100, 4'b0000, 1);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd2, 4'b0100, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd2,   0, 2'd2, 4'b0000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 1, 2'd0,   0, 2'd2, 4'b0000, 4'b0000, 1);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   0, 2'd2, 4'b0000, 4'b0000, 0);
    // pulse on the ack edge of the same source: set wins, no overrun
    add(4'b1000, 0, 4'b0000, 0, 2'd0,   0, 2'd2, 4'b1000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd3, 4'b1000, 4'b0000, 0);
    add(4'b1000, 0, 4'b0000, 1, 2'd3,   0, 2'd3, 4'b1000, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 2'd0,   1, 2'd3, 4'b1000, 4'b0000, 0);
    add(4'b1000, 0, 4'b0000, 0, 2'd0,   1, 2'd3, 4'b1000, 4'b1000, 0);

    // Reset state
    drive(1, '0, 0, '0, 0, '0);
    drive(1, '0, 0, '0, 0, '0);
    chk("reset irq",     32'(bus.irq),     32'd0);
    chk("reset irq_id",  32'(bus.irq_id),  32'd0);
    chk("reset pending", 32'(bus.pending), 32'd0);
    chk("reset overrun", 32'(bus.overrun), 32'd0);
    chk("reset ack_err", 32'(bus.ack_err), 32'd0);
    chk("reset mask",    32'(bus.dbg_mask), 32'hf);

    // Directed table
    foreach (vq[k]) begin
      drive(0, vq[k].pulse, vq[k].mwe, vq[k].mwd, vq[k].ackv, vq[k].ackid);
      chk($sformatf("row%0d irq", k),     32'(bus.irq),     32'(vq[k].e_irq));
      chk($sformatf("row%0d irq_id", k),  32'(bus.irq_id),  32'(vq[k].e_id));
      chk($sformatf("row%0d pending", k), 32'(bus.pending), 32'(vq[k].e_pend));
      chk($sformatf("row%0d overrun", k), 32'(bus.overrun), 32'(vq[k].e_ovr));
      chk($sformatf("row%0d ack_err", k), 32'(bus.ack_err), 32'(vq[k].e_err));
    end

    // Reset while a request is in service (source 3 active, overrun set)
    chk("pre-reset state", 32'(bus.dbg_state), 32'(IRQ_ACTIVE));
    drive(0, '0, 1, 4'b0101, 0, '0);
    drive(1, '0, 0, '0, 0, '0);
    chk("midrst irq",     32'(bus.irq),       32'd0);
    chk("midrst irq_id",  32'(bus.irq_id),    32'd0);
    chk("midrst pending", 32'(bus.pending),   32'd0);
    chk("midrst overrun", 32'(bus.overrun),   32'd0);
    chk("midrst state",   32'(bus.dbg_state), 32'(IRQ_IDLE));
    chk("midrst mask",    32'(bus.dbg_mask),  32'hf);
    // No ack needed after reset: source 1 is served directly
    drive(0, 4'b0010, 0, '0, 0, '0);
    drive(0, '0, 0, '0, 0, '0);
    chk("post-rst irq",    32'(bus.irq),    32'd1);
    chk("post-rst irq_id", 32'(bus.irq_id), 32'd1);

    // Random phase against the model
    drive(1, '0, 0, '0, 0, '0);
    for (int c = 0; c < 1500; c++) begin
      logic [NS-1:0] p;
      logic [NS-1:0] md;
      logic [IW-1:0] aid;
      bit mw, av, rs;
      for (int i = 0; i < NS; i++) p[i] = ($urandom_range(0, 7) == 0);
      mw = ($urandom_range(0, 15) == 0);
      md = NS'($urandom_range(0, (1 << NS) - 1));
      av = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      aid = ($urandom_range(0, 3) != 0) ? IW'(m_id) : IW'($urandom_range(0, NS - 1));
      rs = ($urandom_range(0, 299) == 0);
      drive(rs, p, mw, md, av, aid);
      exp_q.push_back({m_busy, IW'(m_id), to_vec(m_pend), to_vec(m_ovr), m_err});
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d irq", c),     32'(bus.irq),     32'(e[11]));
      chk($sformatf("rnd%0d irq_id", c),  32'(bus.irq_id),  32'(e[10:9]));
      chk($sformatf("rnd%0d pending", c), 32'(bus.pending), 32'(e[8:5]));
      chk($sformatf("rnd%0d overrun", c), 32'(bus.overrun), 32'(e[4:1]));
      chk($sformatf("rnd%0d ack_err", c), 32'(bus.ack_err), 32'(e[0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_irq_ctrl
